// File: rtl/pipe_skid_reg.sv
// Two-slot skid register for a multi-lane issue group.
// in_ready is registered so out_ready never reaches upstream combinationally.
module pipe_skid_reg #(
   parameter int WIDTH = 66,
   parameter int LANES = 2,
   parameter int CNTW  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [LANES-1:0]       in_valid,
   input  logic [LANES-1:0]       in_kill,
   input  logic [LANES*WIDTH-1:0] in_data,
   output logic                   in_ready,
   output logic [LANES-1:0]       out_valid,
   output logic [LANES*WIDTH-1:0] out_data,
   input  logic                   out_ready,
   output logic [1:0]             occupancy,
   output logic [CNTW-1:0]        stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [LANES-1:0]       head_vld_q, head_vld_d;
   logic [LANES*WIDTH-1:0] head_dat_q, head_dat_d;
   logic [LANES-1:0]       skid_vld_q, skid_vld_d;
   logic [LANES*WIDTH-1:0] skid_dat_q, skid_dat_d;
   logic                   rdy_q, rdy_d;
   logic [CNTW-1:0]        cnt_q, cnt_d;

   logic [LANES-1:0] eff_vld;
   logic             in_fire;
   logic             out_fire;
   logic             stall;

   assign eff_vld  = in_valid & ~in_kill;
   assign in_fire  = rdy_q & (|eff_vld);
   assign out_fire = out_ready & (|head_vld_q);
   assign stall    = (|in_valid) & ~rdy_q & ~flush;

   always_comb begin
      state_d    = state_q;
      head_vld_d = head_vld_q;
      head_dat_d = head_dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (flush) begin
         state_d    = ST_EMPTY;
         head_vld_d = '0;
         skid_vld_d = '0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d    = ST_ONE;
                  head_vld_d = eff_vld;
                  head_dat_d = in_data;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  head_vld_d = eff_vld;
                  head_dat_d = in_data;
               end else if (in_fire) begin
                  state_d    = ST_TWO;
                  skid_vld_d = eff_vld;
                  skid_dat_d = in_data;
               end else if (out_fire) begin
                  state_d    = ST_EMPTY;
                  head_vld_d = '0;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only the drain path exists
               if (out_fire) begin
                  state_d    = ST_ONE;
                  head_vld_d = skid_vld_q;
                  head_dat_d = skid_dat_q;
                  skid_vld_d = '0;
               end
            end
            default: begin
               state_d    = ST_EMPTY;
               head_vld_d = '0;
               skid_vld_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      rdy_d = (state_d != ST_TWO);
      cnt_d = cnt_q;
      if (stall && (cnt_q != {CNTW{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         head_vld_q <= '0;
         head_dat_q <= '0;
         skid_vld_q <= '0;
         skid_dat_q <= '0;
         rdy_q      <= 1'b1;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         head_vld_q <= head_vld_d;
         head_dat_q <= head_dat_d;
         skid_vld_q <= skid_vld_d;
         skid_dat_q <= skid_dat_d;
         rdy_q      <= rdy_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = head_vld_q;
   assign out_data  = head_dat_q;
   assign occupancy = state_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg at WIDTH=8, LANES=2, CNTW=4.
module tb_pipe_skid_reg;

   localparam int WIDTH = 8;
   localparam int LANES = 2;
   localparam int CNTW  = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   flush;
   logic [LANES-1:0]       in_valid;
   logic [LANES-1:0]       in_kill;
   logic [LANES*WIDTH-1:0] in_data;
   logic                   in_ready;
   logic [LANES-1:0]       out_valid;
   logic [LANES*WIDTH-1:0] out_data;
   logic                   out_ready;
   logic [1:0]             occupancy;
   logic [CNTW-1:0]        stall_cnt;

   int tests = 0;
   int fails = 0;

   pipe_skid_reg #(
      .WIDTH(WIDTH),
      .LANES(LANES),
      .CNTW (CNTW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_kill  (in_kill),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [1:0] v, input logic [1:0] k,
                        input logic [15:0] d);
      in_valid = v;
      in_kill  = k;
      in_data  = d;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      offer(2'b00, 2'b00, 16'h0);
      tick();
      tick();
      reset = 1'b0;
      chk("rst_occ", occupancy, 0);
      chk("rst_rdy", in_ready, 1);
      chk("rst_ov", out_valid, 0);
      chk("rst_od", out_data, 0);
      chk("rst_cnt", stall_cnt, 0);

      // streaming
      out_ready = 1'b1;
      offer(2'b11, 2'b00, 16'h0201);
      tick();
      chk("str0_od", out_data, 16'h0201);
      chk("str0_ov", out_valid, 2'b11);
      chk("str0_occ", occupancy, 1);
      offer(2'b11, 2'b00, 16'h0403);
      tick();
      chk("str1_od", out_data, 16'h0403);
      chk("str1_occ", occupancy, 1);
      chk("str1_rdy", in_ready, 1);
      offer(2'b11, 2'b00, 16'h0605);
      tick();
      chk("str2_od", out_data, 16'h0605);
      chk("str2_occ", occupancy, 1);
      chk("str2_rdy", in_ready, 1);
      offer(2'b00, 2'b00, 16'h0);
      tick();
      chk("str_drain_occ", occupancy, 0);
      chk("str_drain_ov", out_valid, 0);

      // backpressure
      out_ready = 1'b0;
      offer(2'b11, 2'b00, 16'h1111);
      tick();
      chk("bp_a_occ", occupancy, 1);
      chk("bp_a_rdy", in_ready, 1);
      offer(2'b11, 2'b00, 16'h2222);
      tick();
      chk("bp_b_occ", occupancy, 2);
      chk("bp_b_rdy", in_ready, 0);
      chk("bp_b_od", out_data, 16'h1111);
      offer(2'b00, 2'b00, 16'h0);
      tick();
      chk("bp_hold_od", out_data, 16'h1111);
      chk("bp_hold_occ", occupancy, 2);
      out_ready = 1'b1;
      tick();
      chk("bp_a_left_od", out_data, 16'h2222);
      chk("bp_a_left_occ", occupancy, 1);
      chk("bp_a_left_rdy", in_ready, 1);
      tick();
      chk("bp_b_left_occ", occupancy, 0);
      chk("bp_b_left_ov", out_valid, 0);

      // kill
      out_ready = 1'b0;
      offer(2'b11, 2'b10, 16'hAA55);
      tick();
      chk("kill_ov", out_valid, 2'b01);
      chk("kill_od_lo", out_data[7:0], 8'h55);
      chk("kill_occ", occupancy, 1);
      offer(2'b11, 2'b11, 16'hBEEF);
      tick();
      chk("killall_occ", occupancy, 1);
      chk("killall_ov", out_valid, 2'b01);
      chk("killall_od_lo", out_data[7:0], 8'h55);

      // flush from TWO with a group offered
      offer(2'b11, 2'b00, 16'h3333);
      tick();
      chk("fl_two_occ", occupancy, 2);
      chk("fl_cnt0", stall_cnt, 0);
      flush = 1'b1;
      offer(2'b11, 2'b00, 16'hCCCC);
      tick();
      flush = 1'b0;
      chk("fl_occ", occupancy, 0);
      chk("fl_ov", out_valid, 0);
      chk("fl_rdy", in_ready, 1);
      chk("fl_cnt", stall_cnt, 0);
      offer(2'b00, 2'b00, 16'h0);
      out_ready = 1'b1;
      tick();
      chk("fl_noc_ov", out_valid, 0);
      chk("fl_noc_occ", occupancy, 0);

      // stall counter saturation
      out_ready = 1'b0;
      offer(2'b11, 2'b00, 16'h4444);
      tick();
      offer(2'b11, 2'b00, 16'h5555);
      tick();
      chk("st_two_occ", occupancy, 2);
      offer(2'b01, 2'b00, 16'h6666);
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk($sformatf("st_cnt_%0d", i), stall_cnt, (i > 15) ? 15 : i);
      end
      chk("st_occ", occupancy, 2);
      chk("st_od", out_data, 16'h4444);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("st_rst_cnt", stall_cnt, 0);
      chk("st_rst_occ", occupancy, 0);

      // reset mid-operation
      offer(2'b11, 2'b00, 16'h7777);
      tick();
      chk("mid_occ1", occupancy, 1);
      chk("mid_od1", out_data, 16'h7777);
      offer(2'b11, 2'b00, 16'h8888);
      out_ready = 1'b1;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      offer(2'b00, 2'b00, 16'h0);
      chk("mid_ov", out_valid, 0);
      chk("mid_od", out_data, 0);
      chk("mid_rdy", in_ready, 1);
      chk("mid_occ", occupancy, 0);
      tick();
      chk("mid_after_ov", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 66, payload bits per lane.
- LANES, 2, issue lanes per group.
- CNTW, 16, stall-counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- flush, in, 1, synchronous squash of all stored groups.
- in_valid, in, LANES, per-lane valid of the offered group.
- in_kill, in, LANES, per-lane squash applied at acceptance.
- in_data, in, LANES*WIDTH, lane i occupies bits [i*WIDTH +: WIDTH].
- in_ready, out, 1, stage can accept a group this cycle.
- out_valid, out, LANES, per-lane valid of the head group.
- out_data, out, LANES*WIDTH, head group payload.
- out_ready, in, 1, downstream accepts the head group.
- occupancy, out, 2, stored groups: 0, 1 or 2.
- stall_cnt, out, CNTW, saturating upstream-stall cycle counter.

Function
REQ-003 Storage SHALL be two group slots, HEAD and SKID, each holding LANES valid bits and LANES*WIDTH data.
REQ-004 State SHALL be EMPTY, ONE (HEAD full) or TWO (HEAD and SKID full); occupancy SHALL encode EMPTY=0, ONE=1, TWO=2.
REQ-005 in_ready SHALL equal (state != TWO), driven from a register with no combinational path from out_ready.
REQ-006 Input fire SHALL be in_ready & |(in_valid & ~in_kill).
REQ-007 A group whose effective valid (in_valid & ~in_kill) is all-zero SHALL be treated as a bubble and not stored.
REQ-008 Output fire SHALL be out_ready & |out_valid.
REQ-009 out_valid and out_data SHALL come directly from HEAD; out_valid SHALL be 0 in EMPTY.
REQ-010 A stored group's lane valid bits SHALL be in_valid & ~in_kill sampled at input fire.
REQ-011 Transitions from EMPTY: input fire -> ONE, group in HEAD.
REQ-012 Transitions from ONE:
- input fire only -> TWO, group in SKID.
- output fire only -> EMPTY.
- both -> ONE, new group in HEAD.
REQ-013 Transitions from TWO:
- output fire -> ONE, SKID moves to HEAD.
- no input fire is possible because in_ready=0.
REQ-014 Group order SHALL be strictly FIFO; lanes within a group SHALL never be reordered or split.
REQ-015 HEAD contents SHALL be held stable while out_valid!=0 and out_ready=0.
REQ-016 flush=1 SHALL, at the next edge, clear all slot valid bits, set state EMPTY and set in_ready=1.
REQ-017 Any input or output fire in the flush cycle SHALL be discarded; flush SHALL take priority over every other event.
REQ-018 stall_cnt SHALL increment by 1 each cycle with |in_valid & ~in_ready & ~flush.
REQ-019 stall_cnt SHALL saturate at 2^CNTW-1 and SHALL NOT wrap.
REQ-020 Data bits SHALL be written only on input fire or SKID-to-HEAD move, so idle cycles cause no data toggling.
REQ-021 At most one group SHALL enter and one SHALL leave per cycle; full throughput of one group per cycle SHALL be sustained while out_ready=1.

Reset
REQ-022 reset=1 SHALL, at the next edge, force state EMPTY, all valid bits 0, all slot data 0, in_ready=1, occupancy=0 and stall_cnt=0.
REQ-023 reset SHALL override flush and any handshake in the same cycle.
REQ-024 reset asserted mid-transfer SHALL lose all stored groups with no partial output.

Verification
(Benches run WIDTH=8, LANES=2, CNTW=4.)
REQ-025 Streaming:
- Stimulus: in_valid=11, out_ready=1, data 0x0201, 0x0403, 0x0605 on consecutive cycles.
- Response: the same data emerges on the following cycles in order, occupancy stays 1, in_ready stays 1.
REQ-026 Backpressure:
- Stimulus: out_ready=0, offer groups A=0x1111 then B=0x2222.
- Response: occupancy reaches 2 and in_ready=0 on the cycle after B.
- Stimulus: raise out_ready.
- Response: A then B delivered, with in_ready=1 one cycle after A leaves.
REQ-027 Kill:
- Stimulus: in_valid=11, in_kill=10, data 0xAA55.
- Response: out_valid=01, out_data[7:0]=0x55.
- Stimulus: in_valid=11, in_kill=11.
- Response: no group stored, occupancy unchanged.
REQ-028 Flush:
- Stimulus: TWO state, then flush=1 together with an offered group C.
- Response: next cycle occupancy=0, out_valid=00, in_ready=1, and C is never output.
REQ-029 Stall counter:
- Stimulus: hold the TWO state with in_valid=01 for 20 cycles.
- Response: stall_cnt reaches 15 and holds 15; reset returns it to 0.
REQ-030 Reset mid-operation:
- Stimulus: reset=1 in state ONE with out_ready=1.
- Response: next cycle out_valid=00, out_data=0, in_ready=1, occupancy=0.
